// File: rtl/signed_2s_comp_sub_seq_if.sv
// Operand/result handshake bundle for the
// chunked signed subtractor.
interface signed_2s_comp_sub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s_sub;
  logic             ovf;

  modport master (
    output in_valid,
    input  in_ready,
    output num1,
    output num2,
    input  out_valid,
    output out_ready,
    input  s_sub,
    input  ovf
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  num1,
    input  num2,
    output out_valid,
    input  out_ready,
    output s_sub,
    output ovf
  );
endinterface

// File: rtl/signed_2s_comp_sub_seq.sv
// Multi-cycle signed subtractor, CHUNK bits/clk, LSB first.
// SIGNED_SUB_SAT_EN: saturate s_sub on signed overflow.
module signed_2s_comp_sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  signed_2s_comp_sub_seq_if.slave   io
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] res_fin;
  logic             ovf_nxt;
  int               base;

  always_comb begin
    base = int'(cnt_q) * CHUNK;
    sum  = {1'b0, a_q[base +: CHUNK]}
         + {1'b0, b_q[base +: CHUNK]}
         + {{CHUNK{1'b0}}, carry_q};
    res_nxt = res_q;
    res_nxt[base +: CHUNK] = sum[CHUNK-1:0];
    // b_q holds ~num2, so equal MSBs mean
    // the original operand signs differ
    ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1])
           && (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SIGNED_SUB_SAT_EN
    if (ovf_nxt)
      res_fin = a_q[WIDTH-1] ? SMIN : SMAX;
    else
      res_fin = res_nxt;
`else
    res_fin = res_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_q     <= io.num1;
            b_q     <= ~io.num2;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          carry_q <= sum[CHUNK];
          if (cnt_q == LAST) begin
            res_q <= res_fin;
            ovf_q <= ovf_nxt;
            cnt_q <= '0;
            state <= DONE;
          end else begin
            res_q <= res_nxt;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.s_sub     = res_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_signed_2s_comp_sub_seq.sv
// Scoreboard bench for signed_2s_comp_sub_seq:
// directed vectors, queue of expected results.
module tb_signed_2s_comp_sub_seq;
  logic clk;
  logic rst_n;

  signed_2s_comp_sub_seq_if #(.WIDTH(32)) io();

  signed_2s_comp_sub_seq #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  typedef struct {
    logic [31:0] s;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  // monitor: handshake will complete on the next rising edge
  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got %h/%b",
                 io.s_sub, io.ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (io.s_sub !== e.s || io.ovf !== e.o) begin
          errors++;
          $display("FAIL result got %h/%b want %h/%b",
                   io.s_sub, io.ovf, e.s, e.o);
        end
      end
    end
  end

  // returns at the falling edge right after the accept edge
  task automatic do_op(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] es,
                       input logic        eo,
                       input bit          push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.num1 = a;
    io.num2 = b;
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got 0 want 1");
    end else if (push) begin
      e.s = es;
      e.o = eo;
      exp_q.push_back(e);
    end
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] w_pos;
  logic [31:0] w_neg;
  logic [31:0] w_zn;
  int          lat;

  initial begin
`ifdef SIGNED_SUB_SAT_EN
    w_pos = 32'h7FFF_FFFF;
    w_neg = 32'h8000_0000;
    w_zn  = 32'h7FFF_FFFF;
`else
    w_pos = 32'h8000_0000;
    w_neg = 32'h7FFF_FFFF;
    w_zn  = 32'h8000_0000;
`endif
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.num1 = '0;
    io.num2 = '0;
    io.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_s_sub", io.s_sub, 32'd0);
    chk("rst_ovf", 32'(io.ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // latency and in_ready return
    do_op(32'd7, 32'd3, 32'd4, 1'b0, 1'b1);
    lat = 0;
    while (!io.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("in_ready_in_done", 32'(io.in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_after_hs", 32'(io.in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(io.out_valid), 32'd0);
    drain();

    do_op(32'd5, 32'hFFFF_FFFD, 32'd8, 1'b0, 1'b1);
    do_op(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFF8, 1'b0, 1'b1);
    do_op(32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, w_pos, 1'b1, 1'b1);
    do_op(32'h8000_0000, 32'd1, w_neg, 1'b1, 1'b1);
    do_op(32'd0, 32'h8000_0000, w_zn, 1'b1, 1'b1);
    do_op(32'hFFFF_FFFF, 32'h7FFF_FFFF,
          32'h8000_0000, 1'b0, 1'b1);
    do_op(32'h0000_0100, 32'd1, 32'h0000_00FF, 1'b0, 1'b1);
    drain();

    // backpressure plus ignored in_valid pulses
    io.out_ready = 1'b0;
    do_op(32'd1000, 32'd1, 32'd999, 1'b0, 1'b1);
    io.in_valid = 1'b1;
    io.num1 = 32'd100;
    io.num2 = 32'd1;
    @(negedge clk);
    io.in_valid = 1'b0;
    lat = 0;
    while (!io.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    io.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_s_sub", io.s_sub, 32'd999);
      chk("bp_ovf", 32'(io.ovf), 32'd0);
      chk("bp_in_ready", 32'(io.in_ready), 32'd0);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    drain();
    repeat (8) @(negedge clk);
    chk("no_phantom_valid", 32'(io.out_valid), 32'd0);

    // async reset during the 2nd CALC cycle
    do_op(32'd55, 32'd11, 32'd44, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_s_sub", io.s_sub, 32'd0);
    chk("mid_rst_ovf", 32'(io.ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_no_valid", 32'(io.out_valid), 32'd0);
    do_op(32'd10, 32'd20, 32'hFFFF_FFF6, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
